// File: rtl/stream_merge_rr.sv
// stream_merge_rr
//   Merges two valid/ready payload streams (A and B) into one output stream.
//   Each channel has a private FIFO of 2**A_WIDTH entries. A round-robin
//   arbiter pops one FIFO head per cycle into a single output register.
//   Grants strictly alternate when both FIFOs hold data. A wins the first
//   tie after reset.
//
// Ports
//   clk         in   clock, all state updates on rising edge
//   rst         in   synchronous active-high reset
//   up_data_a   in   channel A payload     [D_WIDTH]
//   up_valid_a  in   channel A valid
//   up_ready_a  out  channel A FIFO can accept (registered state only)
//   up_data_b   in   channel B payload     [D_WIDTH]
//   up_valid_b  in   channel B valid
//   up_ready_b  out  channel B FIFO can accept (registered state only)
//   down_data   out  merged payload        [D_WIDTH]
//   down_src    out  source of down_data (0 = A, 1 = B)
//   down_valid  out  merged payload valid
//   down_ready  in   downstream accepts
module stream_merge_rr #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data_a,
  input  logic               up_valid_a,
  output logic               up_ready_a,
  input  logic [D_WIDTH-1:0] up_data_b,
  input  logic               up_valid_b,
  output logic               up_ready_b,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_src,
  output logic               down_valid,
  input  logic               down_ready
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH+1)'(DEPTH);

  logic [D_WIDTH-1:0] mem_a_q [DEPTH];
  logic [D_WIDTH-1:0] mem_b_q [DEPTH];

  logic [A_WIDTH-1:0] wp_a_q, wp_a_d, rp_a_q, rp_a_d;
  logic [A_WIDTH-1:0] wp_b_q, wp_b_d, rp_b_q, rp_b_d;
  logic [A_WIDTH:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  // run_q holds both ready outputs low while in reset and releases them
  // on the first edge after reset is deasserted.
  logic               run_q;
  logic               last_q, last_d;   // last granted channel: 0 = A, 1 = B
  logic               dv_q, dv_d;
  logic [D_WIDTH-1:0] dd_q, dd_d;
  logic               ds_q, ds_d;

  logic wr_a, wr_b, ne_a, ne_b, load_en, gnt_a, gnt_b;

  assign up_ready_a = run_q && (cnt_a_q < FULL_CNT);
  assign up_ready_b = run_q && (cnt_b_q < FULL_CNT);
  assign down_data  = dd_q;
  assign down_src   = ds_q;
  assign down_valid = dv_q;

  always_comb begin
    wr_a    = up_valid_a && up_ready_a;
    wr_b    = up_valid_b && up_ready_b;
    ne_a    = (cnt_a_q != '0);
    ne_b    = (cnt_b_q != '0);
    load_en = !dv_q || down_ready;

    // B wins only when A is empty or A was served last.
    gnt_b   = load_en && ne_b && (!ne_a || !last_q);
    gnt_a   = load_en && ne_a && !gnt_b;

    wp_a_d  = wr_a  ? wp_a_q + A_WIDTH'(1) : wp_a_q;
    wp_b_d  = wr_b  ? wp_b_q + A_WIDTH'(1) : wp_b_q;
    rp_a_d  = gnt_a ? rp_a_q + A_WIDTH'(1) : rp_a_q;
    rp_b_d  = gnt_b ? rp_b_q + A_WIDTH'(1) : rp_b_q;
    cnt_a_d = cnt_a_q + (A_WIDTH+1)'(wr_a) - (A_WIDTH+1)'(gnt_a);
    cnt_b_d = cnt_b_q + (A_WIDTH+1)'(wr_b) - (A_WIDTH+1)'(gnt_b);

    dv_d   = dv_q;
    dd_d   = dd_q;
    ds_d   = ds_q;
    last_d = last_q;
    if (load_en) begin
      dv_d = gnt_a || gnt_b;
      if (gnt_a) begin
        dd_d   = mem_a_q[rp_a_q];
        ds_d   = 1'b0;
        last_d = 1'b0;
      end else if (gnt_b) begin
        dd_d   = mem_b_q[rp_b_q];
        ds_d   = 1'b1;
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_a_q  <= '0;
      rp_a_q  <= '0;
      cnt_a_q <= '0;
      wp_b_q  <= '0;
      rp_b_q  <= '0;
      cnt_b_q <= '0;
      run_q   <= 1'b0;
      last_q  <= 1'b1;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      ds_q    <= 1'b0;
    end else begin
      wp_a_q  <= wp_a_d;
      rp_a_q  <= rp_a_d;
      cnt_a_q <= cnt_a_d;
      wp_b_q  <= wp_b_d;
      rp_b_q  <= rp_b_d;
      cnt_b_q <= cnt_b_d;
      run_q   <= 1'b1;
      last_q  <= last_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      ds_q    <= ds_d;
    end
  end

  // Storage needs no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (!rst && wr_a) mem_a_q[wp_a_q] <= up_data_a;
    if (!rst && wr_b) mem_b_q[wp_b_q] <= up_data_b;
  end

endmodule

// File: tb/tb_stream_merge_rr.sv
module tb_stream_merge_rr;

  localparam int DW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] up_data_a, up_data_b;
  logic          up_valid_a, up_valid_b;
  logic          up_ready_a, up_ready_b;
  logic [DW-1:0] down_data;
  logic          down_src, down_valid;
  logic          down_ready;

  stream_merge_rr #(.D_WIDTH(DW), .A_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data_a  (up_data_a),
    .up_valid_a (up_valid_a),
    .up_ready_a (up_ready_a),
    .up_data_b  (up_data_b),
    .up_valid_b (up_valid_b),
    .up_ready_b (up_ready_b),
    .down_data  (down_data),
    .down_src   (down_src),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // stimulus: words waiting to be offered on each channel
  logic [DW-1:0] sq_a[$], sq_b[$];
  bit            gate_a = 1'b1, gate_b = 1'b1;

  // behavioural model: buffered words, output register, last winner
  logic [DW-1:0] m_qa[$], m_qb[$];
  bit            m_v, m_s, m_last, m_rdy_en;
  logic [DW-1:0] m_d;
  logic [DW:0]   log_q[$];          // {src,data} of every completed output transfer

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit ra, rb, ga, gb;
    started = 1'b1;
    if (rst) begin
      m_qa.delete();
      m_qb.delete();
      m_v = 0; m_d = '0; m_s = 0; m_last = 1; m_rdy_en = 0;
    end else begin
      ra = m_rdy_en && (m_qa.size() < DEPTH);
      rb = m_rdy_en && (m_qb.size() < DEPTH);
      if (m_v && down_ready) log_q.push_back({m_s, m_d});
      if (!m_v || down_ready) begin
        ga = 0; gb = 0;
        if (m_qa.size() > 0 && m_qb.size() > 0) begin
          if (m_last) ga = 1; else gb = 1;
        end else if (m_qa.size() > 0) ga = 1;
        else if (m_qb.size() > 0) gb = 1;
        if (ga) begin
          m_d = m_qa.pop_front(); m_s = 0; m_v = 1; m_last = 0;
        end else if (gb) begin
          m_d = m_qb.pop_front(); m_s = 1; m_v = 1; m_last = 1;
        end else m_v = 0;
      end
      if (up_valid_a && ra) begin
        m_qa.push_back(up_data_a);
        if (sq_a.size() > 0) void'(sq_a.pop_front());
      end
      if (up_valid_b && rb) begin
        m_qb.push_back(up_data_b);
        if (sq_b.size() > 0) void'(sq_b.pop_front());
      end
      m_rdy_en = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready_a", 32'(up_ready_a), 32'(m_rdy_en && (m_qa.size() < DEPTH)));
      chk("ready_b", 32'(up_ready_b), 32'(m_rdy_en && (m_qb.size() < DEPTH)));
      chk("down_valid", 32'(down_valid), 32'(m_v));
      if (m_v) begin
        chk("down_data", 32'(down_data), 32'(m_d));
        chk("down_src", 32'(down_src), 32'(m_s));
      end
    end
  end

  // drive inputs for the coming edge, then advance to the following negedge
  task automatic step();
    up_valid_a = gate_a && (sq_a.size() != 0);
    up_data_a  = (sq_a.size() != 0) ? sq_a[0] : '0;
    up_valid_b = gate_b && (sq_b.size() != 0);
    up_data_b  = (sq_b.size() != 0) ? sq_b[0] : '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sq_a.delete();
    sq_b.delete();
    gate_a = 1'b1;
    gate_b = 1'b1;
    step();
    step();
    chk("rst_ready_a", 32'(up_ready_a), 0);
    chk("rst_ready_b", 32'(up_ready_b), 0);
    chk("rst_valid", 32'(down_valid), 0);
    chk("rst_data", 32'(down_data), 0);
    chk("rst_src", 32'(down_src), 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready_a", 32'(up_ready_a), 1);
    chk("post_rst_ready_b", 32'(up_ready_b), 1);
  endtask

  initial begin
    logic [DW:0]   exp_t2[4];
    logic [DW-1:0] ref_a[$], ref_b[$], la[$], lb[$];
    int nv, first, last;

    rst = 1'b1; down_ready = 1'b0;
    up_valid_a = 0; up_valid_b = 0; up_data_a = '0; up_data_b = '0;

    // single word latency
    do_reset();
    down_ready = 1'b1;
    sq_a.push_back(6'h15);
    step();
    chk("t1_valid_n", 32'(down_valid), 0);
    step();
    chk("t1_valid_n1", 32'(down_valid), 1);
    chk("t1_data", 32'(down_data), 32'h15);
    chk("t1_src", 32'(down_src), 0);
    step();
    chk("t1_valid_after", 32'(down_valid), 0);

    // tie arbitration after reset
    do_reset();
    down_ready = 1'b1;
    log_q.delete();
    sq_a.push_back(6'h01); sq_a.push_back(6'h02);
    sq_b.push_back(6'h21); sq_b.push_back(6'h22);
    repeat (8) step();
    exp_t2[0] = {1'b0, 6'h01};
    exp_t2[1] = {1'b1, 6'h21};
    exp_t2[2] = {1'b0, 6'h02};
    exp_t2[3] = {1'b1, 6'h22};
    chk("t2_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(exp_t2[i]));

    // backpressure until full, then output stability, then release
    do_reset();
    down_ready = 1'b0;
    log_q.delete();
    for (int i = 0; i < 6; i++) sq_a.push_back(6'(8'h31 + i));
    repeat (8) step();
    chk("t3_ready_a_full", 32'(up_ready_a), 0);
    chk("t3_left_over", sq_a.size(), 1);
    chk("t3_valid", 32'(down_valid), 1);
    chk("t3_head", 32'(down_data), 32'h31);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stable_valid", 32'(down_valid), 1);
      chk("t5_stable_data", 32'(down_data), 32'h31);
      chk("t5_stable_src", 32'(down_src), 0);
    end
    down_ready = 1'b1;
    repeat (10) step();
    chk("t3_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t3_order", (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(8'h31 + i));

    // single channel throughput on B
    do_reset();
    down_ready = 1'b1;
    for (int i = 0; i < 8; i++) sq_b.push_back(6'(8 + i));
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (down_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
        chk("t4_src", 32'(down_src), 1);
      end
    end
    chk("t4_valid_count", nv, 8);
    chk("t4_consecutive", last - first, 7);

    // mid-run reset discards everything
    do_reset();
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) sq_a.push_back(6'(1 + i));
    for (int i = 0; i < 3; i++) sq_b.push_back(6'(9 + i));
    repeat (6) step();
    log_q.delete();
    rst = 1'b1;
    sq_a.delete(); sq_b.delete();
    step();
    chk("t6_rst_valid", 32'(down_valid), 0);
    chk("t6_rst_ready_a", 32'(up_ready_a), 0);
    chk("t6_rst_ready_b", 32'(up_ready_b), 0);
    rst = 1'b0;
    step();
    chk("t6_ready_back", 32'(up_ready_a), 1);
    down_ready = 1'b1;
    sq_a.push_back(6'h2A);
    step();
    chk("t6_lat_n", 32'(down_valid), 0);
    step();
    chk("t6_lat_valid", 32'(down_valid), 1);
    chk("t6_lat_data", 32'(down_data), 32'h2A);
    repeat (6) step();
    chk("t6_count", log_q.size(), 1);
    chk("t6_only_new", (log_q.size() > 0) ? 32'(log_q[0]) : 32'hFFFF_FFFF, 32'({1'b0, 6'h2A}));

    // randomized traffic with random backpressure, then drain
    do_reset();
    log_q.delete();
    for (int c = 0; c < 1500; c++) begin
      gate_a = ($urandom_range(0, 3) != 0);
      gate_b = ($urandom_range(0, 3) != 0);
      down_ready = ($urandom_range(0, 3) != 0);
      if (sq_a.size() < 3 && $urandom_range(0, 1) == 1) begin
        sq_a.push_back(6'($urandom_range(0, 63)));
        ref_a.push_back(sq_a[sq_a.size()-1]);
      end
      if (sq_b.size() < 3 && $urandom_range(0, 1) == 1) begin
        sq_b.push_back(6'($urandom_range(0, 63)));
        ref_b.push_back(sq_b[sq_b.size()-1]);
      end
      step();
    end
    gate_a = 1; gate_b = 1; down_ready = 1;
    repeat (30) step();
    foreach (log_q[i]) begin
      if (log_q[i][DW]) lb.push_back(log_q[i][DW-1:0]);
      else la.push_back(log_q[i][DW-1:0]);
    end
    chk("rnd_count_a", la.size(), ref_a.size());
    chk("rnd_count_b", lb.size(), ref_b.size());
    foreach (ref_a[i])
      chk("rnd_order_a", (i < la.size()) ? 32'(la[i]) : 32'hFFFF_FFFF, 32'(ref_a[i]));
    foreach (ref_b[i])
      chk("rnd_order_b", (i < lb.size()) ? 32'(lb[i]) : 32'hFFFF_FFFF, 32'(ref_b[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
